// File: rtl/gpr_pkg.sv
// Shared constants for the general-purpose register bank: default sizing,
// step direction encodings and read-port slot numbering.
package gpr_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NUM_REGS = 4;

  // Step direction encodings carried on step_dir
  localparam logic STEP_INC = 1'b0;
  localparam logic STEP_DEC = 1'b1;

  // Read-port slots inside the bank
  localparam int NUM_RD_PORTS = 3;
  localparam int RD_MAIN      = 0;
  localparam int RD_LHS       = 1;
  localparam int RD_RHS       = 2;

  // True when a register index addresses an implemented register
  function automatic logic idx_ok(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One registered read port of the register bank. Selects the post-edge value
// of the addressed register (write data, then step result, then stored value)
// and registers it; a disabled or out-of-range request yields zero.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_sel,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic              wr_ok,
  input  logic [IDX_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              step_ok,
  input  logic [IDX_W-1:0]  step_sel,
  input  logic [DATA_W-1:0] step_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_next;
  logic [DATA_W-1:0] rd_data_reg;

  // Forwarding mux: the value the addressed register will hold after this edge
  always_comb begin
    rd_next = '0;
    if (rd_en && idx_ok(32'(rd_sel), NUM_REGS)) begin
      if (wr_ok && (wr_sel == rd_sel)) begin
        rd_next = wr_data;
      end else if (step_ok && (step_sel == rd_sel)) begin
        rd_next = step_data;
      end else begin
        rd_next = regs[rd_sel];
      end
    end
  end

  // Output stage: one-cycle read latency, zero when not requested
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_next;
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/gpr_bank.sv
// Parametrised general-purpose register bank: one load port from the main bus,
// an in-place increment/decrement port with zero flag, and three registered,
// write-forwarding read ports (main bus, ALU LHS, ALU RHS).
module gpr_bank
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] main_in,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_sel,
  input  logic              step_en,
  input  logic              step_dir,
  input  logic [IDX_W-1:0]  step_sel,
  input  logic              main_rd_en,
  input  logic [IDX_W-1:0]  main_rd_sel,
  input  logic              lhs_en,
  input  logic [IDX_W-1:0]  lhs_sel,
  input  logic              rhs_en,
  input  logic [IDX_W-1:0]  rhs_sel,
  output logic [DATA_W-1:0] main_out,
  output logic              main_valid,
  output logic [DATA_W-1:0] lhs_out,
  output logic [DATA_W-1:0] rhs_out,
  output logic              step_zero,
  output logic              sel_err
);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  logic              wr_ok;
  logic              step_in_range;
  logic              step_collide;
  logic              step_ok;
  logic [DATA_W-1:0] step_cur;
  logic [DATA_W-1:0] step_data;
  logic              sel_bad;

  logic              main_valid_reg;
  logic              step_zero_reg;
  logic              sel_err_reg;

  logic              rd_en_vec   [NUM_RD_PORTS];
  logic [IDX_W-1:0]  rd_sel_vec  [NUM_RD_PORTS];
  logic [DATA_W-1:0] rd_data_vec [NUM_RD_PORTS];

  // Qualify requests: out-of-range indices are dropped, a write beats a step
  // aimed at the same register
  always_comb begin
    wr_ok         = wr_en && idx_ok(32'(wr_sel), NUM_REGS);
    step_in_range = step_en && idx_ok(32'(step_sel), NUM_REGS);
    step_collide  = step_in_range && wr_ok && (wr_sel == step_sel);
    step_ok       = step_in_range && !step_collide;
    step_cur      = step_in_range ? regs_reg[step_sel] : '0;
    step_data     = (step_dir == STEP_DEC) ? (step_cur - DATA_W'(1))
                                           : (step_cur + DATA_W'(1));
    sel_bad       = (wr_en      && !idx_ok(32'(wr_sel),      NUM_REGS)) ||
                    (step_en    && !idx_ok(32'(step_sel),    NUM_REGS)) ||
                    (main_rd_en && !idx_ok(32'(main_rd_sel), NUM_REGS)) ||
                    (lhs_en     && !idx_ok(32'(lhs_sel),     NUM_REGS)) ||
                    (rhs_en     && !idx_ok(32'(rhs_sel),     NUM_REGS));
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // Register gi: load from the main bus, else step in place, else hold
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (wr_ok && (wr_sel == IDX_W'(gi))) begin
          regs_reg[gi] <= main_in;
        end else if (step_ok && (step_sel == IDX_W'(gi))) begin
          regs_reg[gi] <= step_data;
        end
      end
    end
  endgenerate

  assign rd_en_vec[RD_MAIN]  = main_rd_en;
  assign rd_sel_vec[RD_MAIN] = main_rd_sel;
  assign rd_en_vec[RD_LHS]   = lhs_en;
  assign rd_sel_vec[RD_LHS]  = lhs_sel;
  assign rd_en_vec[RD_RHS]   = rhs_en;
  assign rd_sel_vec[RD_RHS]  = rhs_sel;

  generate
    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      gpr_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
      ) u_port (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en_vec[gi]),
        .rd_sel    (rd_sel_vec[gi]),
        .regs      (regs_reg),
        .wr_ok     (wr_ok),
        .wr_sel    (wr_sel),
        .wr_data   (main_in),
        .step_ok   (step_ok),
        .step_sel  (step_sel),
        .step_data (step_data),
        .rd_data   (rd_data_vec[gi])
      );
    end
  endgenerate

  // Status flags: main bus enable, last-step zero flag, sticky index error
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      step_zero_reg  <= 1'b0;
      sel_err_reg    <= 1'b0;
    end else begin
      main_valid_reg <= main_rd_en;
      if (step_collide) begin
        step_zero_reg <= 1'b0;
      end else if (step_ok) begin
        step_zero_reg <= (step_data == '0);
      end
      if (sel_bad) begin
        sel_err_reg <= 1'b1;
      end
    end
  end

  assign main_out   = rd_data_vec[RD_MAIN];
  assign lhs_out    = rd_data_vec[RD_LHS];
  assign rhs_out    = rd_data_vec[RD_RHS];
  assign main_valid = main_valid_reg;
  assign step_zero  = step_zero_reg;
  assign sel_err    = sel_err_reg;

endmodule

// File: tb/tb_gpr_bank.sv
// Bench for gpr_bank: two instances (4 and 3 registers) share one stimulus
// stream; a reference model of the register file predicts every output and
// is compared each cycle, with literal expectations at key points.
module tb_gpr_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] main_in;
  logic       wr_en, step_en, step_dir, main_rd_en, lhs_en, rhs_en;
  logic [1:0] wr_sel, step_sel, main_rd_sel, lhs_sel, rhs_sel;

  logic [7:0] main_out_w [2];
  logic [7:0] lhs_out_w  [2];
  logic [7:0] rhs_out_w  [2];
  logic       main_valid_w [2];
  logic       step_zero_w  [2];
  logic       sel_err_w    [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = 4-register bank, 1 = 3-register bank
  logic [7:0] mdl_mem [2][4];
  logic [7:0] exp_main [2];
  logic [7:0] exp_lhs  [2];
  logic [7:0] exp_rhs  [2];
  logic       exp_valid [2];
  logic       exp_zero  [2];
  logic       exp_err   [2];

  always #5 clk = ~clk;

  gpr_bank #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst), .main_in(main_in), .wr_en(wr_en), .wr_sel(wr_sel),
    .step_en(step_en), .step_dir(step_dir), .step_sel(step_sel),
    .main_rd_en(main_rd_en), .main_rd_sel(main_rd_sel),
    .lhs_en(lhs_en), .lhs_sel(lhs_sel), .rhs_en(rhs_en), .rhs_sel(rhs_sel),
    .main_out(main_out_w[0]), .main_valid(main_valid_w[0]),
    .lhs_out(lhs_out_w[0]), .rhs_out(rhs_out_w[0]),
    .step_zero(step_zero_w[0]), .sel_err(sel_err_w[0])
  );

  gpr_bank #(.DATA_W(8), .NUM_REGS(3)) dut3 (
    .clk(clk), .rst(rst), .main_in(main_in), .wr_en(wr_en), .wr_sel(wr_sel),
    .step_en(step_en), .step_dir(step_dir), .step_sel(step_sel),
    .main_rd_en(main_rd_en), .main_rd_sel(main_rd_sel),
    .lhs_en(lhs_en), .lhs_sel(lhs_sel), .rhs_en(rhs_en), .rhs_sel(rhs_sel),
    .main_out(main_out_w[1]), .main_valid(main_valid_w[1]),
    .lhs_out(lhs_out_w[1]), .rhs_out(rhs_out_w[1]),
    .step_zero(step_zero_w[1]), .sel_err(sel_err_w[1])
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Apply one clock edge of the register-file rules to the model
  task automatic model_update();
    logic [7:0] nxt [4];
    int n;
    bit wr_in, st_in;
    for (int m = 0; m < 2; m++) begin
      n = (m == 0) ? 4 : 3;
      if (rst) begin
        for (int r = 0; r < 4; r++) mdl_mem[m][r] = 8'h00;
        exp_main[m] = 0; exp_lhs[m] = 0; exp_rhs[m] = 0;
        exp_valid[m] = 0; exp_zero[m] = 0; exp_err[m] = 0;
      end else begin
        for (int r = 0; r < 4; r++) nxt[r] = mdl_mem[m][r];
        wr_in = wr_en && (int'(wr_sel) < n);
        st_in = step_en && (int'(step_sel) < n);
        if (st_in && wr_in && (wr_sel == step_sel)) begin
          exp_zero[m] = 1'b0;
        end else if (st_in) begin
          nxt[step_sel] = step_dir ? mdl_mem[m][step_sel] - 8'd1 : mdl_mem[m][step_sel] + 8'd1;
          exp_zero[m] = (nxt[step_sel] == 8'h00);
        end
        if (wr_in) nxt[wr_sel] = main_in;
        exp_main[m]  = (main_rd_en && int'(main_rd_sel) < n) ? nxt[main_rd_sel] : 8'h00;
        exp_lhs[m]   = (lhs_en && int'(lhs_sel) < n) ? nxt[lhs_sel] : 8'h00;
        exp_rhs[m]   = (rhs_en && int'(rhs_sel) < n) ? nxt[rhs_sel] : 8'h00;
        exp_valid[m] = main_rd_en;
        if ((wr_en && int'(wr_sel) >= n) || (step_en && int'(step_sel) >= n) ||
            (main_rd_en && int'(main_rd_sel) >= n) || (lhs_en && int'(lhs_sel) >= n) ||
            (rhs_en && int'(rhs_sel) >= n))
          exp_err[m] = 1'b1;
        for (int r = 0; r < 4; r++) mdl_mem[m][r] = nxt[r];
      end
    end
  endtask

  // Every cycle: both instances against the model
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      check($sformatf("u%0d main_out", m),   main_out_w[m],   exp_main[m]);
      check($sformatf("u%0d lhs_out", m),    lhs_out_w[m],    exp_lhs[m]);
      check($sformatf("u%0d rhs_out", m),    rhs_out_w[m],    exp_rhs[m]);
      check($sformatf("u%0d main_valid", m), 8'(main_valid_w[m]), 8'(exp_valid[m]));
      check($sformatf("u%0d step_zero", m),  8'(step_zero_w[m]),  8'(exp_zero[m]));
      check($sformatf("u%0d sel_err", m),    8'(sel_err_w[m]),    8'(exp_err[m]));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    $display("t=%0t rst=%0b wr=%0b/%0d/%02h step=%0b/%0b/%0d rd m=%0b/%0d l=%0b/%0d r=%0b/%0d -> u0 m=%02h l=%02h r=%02h z=%0b e=%0b | u1 e=%0b",
             $time, rst, wr_en, wr_sel, main_in, step_en, step_dir, step_sel,
             main_rd_en, main_rd_sel, lhs_en, lhs_sel, rhs_en, rhs_sel,
             main_out_w[0], lhs_out_w[0], rhs_out_w[0], step_zero_w[0], sel_err_w[0], sel_err_w[1]);
  endtask

  task automatic idle();
    wr_en = 0; step_en = 0; main_rd_en = 0; lhs_en = 0; rhs_en = 0;
  endtask

  initial begin
    rst = 1; main_in = 0; step_dir = 0;
    wr_sel = 0; step_sel = 0; main_rd_sel = 0; lhs_sel = 0; rhs_sel = 0;
    idle();
    tick(); tick();
    rst = 0;
    check("rst main_out", main_out_w[0], 8'h00);
    check("rst sel_err", 8'(sel_err_w[0]), 8'h00);

    // Read every index on all three ports
    for (int i = 0; i < 4; i++) begin
      main_rd_en = 1; lhs_en = 1; rhs_en = 1;
      main_rd_sel = 2'(i); lhs_sel = 2'(i); rhs_sel = 2'(i);
      tick();
      check("rd valid", 8'(main_valid_w[0]), 8'h01);
      check("rd lhs zero", lhs_out_w[0], 8'h00);
    end
    check("rd u0 sel_err", 8'(sel_err_w[0]), 8'h00);
    check("rd u1 sel_err", 8'(sel_err_w[1]), 8'h01);
    idle(); tick();
    check("idle valid", 8'(main_valid_w[0]), 8'h00);

    // Write / readback
    wr_en = 1; wr_sel = 2; main_in = 8'hA5; tick();
    idle(); lhs_en = 1; lhs_sel = 2; rhs_en = 1; rhs_sel = 2; tick();
    check("wb lhs", lhs_out_w[0], 8'hA5);
    check("wb rhs", rhs_out_w[0], 8'hA5);
    check("wb main off", main_out_w[0], 8'h00);

    // Forwarding of a same-cycle write
    idle(); wr_en = 1; wr_sel = 1; main_in = 8'h11; tick();
    main_in = 8'h3C; lhs_en = 1; lhs_sel = 1; tick();
    check("fwd lhs", lhs_out_w[0], 8'h3C);

    // Step wrap both ways, with forwarded reads
    idle(); wr_en = 1; wr_sel = 3; main_in = 8'hFF; tick();
    idle(); step_en = 1; step_dir = 0; step_sel = 3; lhs_en = 1; lhs_sel = 3; tick();
    check("inc wrap lhs", lhs_out_w[0], 8'h00);
    check("inc wrap zero", 8'(step_zero_w[0]), 8'h01);
    step_dir = 1; tick();
    check("dec wrap lhs", lhs_out_w[0], 8'hFF);
    check("dec wrap zero", 8'(step_zero_w[0]), 8'h00);

    // Write r0 and step r3 together, then collide on r0
    idle(); wr_en = 1; wr_sel = 0; main_in = 8'h10;
    step_en = 1; step_dir = 0; step_sel = 3; tick();
    check("pre-collide zero", 8'(step_zero_w[0]), 8'h01);
    main_in = 8'h55; step_sel = 0; lhs_en = 1; lhs_sel = 0; tick();
    check("collide lhs", lhs_out_w[0], 8'h55);
    check("collide zero", 8'(step_zero_w[0]), 8'h00);
    idle(); wr_en = 1; wr_sel = 0; main_in = 8'h66;
    step_en = 1; step_dir = 0; step_sel = 1; tick();
    idle(); lhs_en = 1; lhs_sel = 0; rhs_en = 1; rhs_sel = 1;
    main_rd_en = 1; main_rd_sel = 3; tick();
    check("both lhs", lhs_out_w[0], 8'h66);
    check("both rhs", rhs_out_w[0], 8'h3D);
    check("both main", main_out_w[0], 8'h00);

    // Out-of-range index on the 3-register bank
    idle(); rst = 1; tick(); rst = 0;
    check("rst2 u1 sel_err", 8'(sel_err_w[1]), 8'h00);
    wr_en = 1; wr_sel = 3; main_in = 8'h77; tick();
    check("bad u1 sel_err", 8'(sel_err_w[1]), 8'h01);
    check("bad u0 sel_err", 8'(sel_err_w[0]), 8'h00);
    idle(); lhs_en = 1; lhs_sel = 3; rhs_en = 1; rhs_sel = 2; main_rd_en = 1; main_rd_sel = 0; tick();
    check("bad u0 lhs", lhs_out_w[0], 8'h77);
    check("bad u1 lhs", lhs_out_w[1], 8'h00);
    idle(); tick(); tick();
    check("held u1 sel_err", 8'(sel_err_w[1]), 8'h01);
    rst = 1; tick(); rst = 0;
    check("clr u1 sel_err", 8'(sel_err_w[1]), 8'h00);
    lhs_en = 1; lhs_sel = 3; tick();
    check("clr u0 r3", lhs_out_w[0], 8'h00);
    idle(); tick();

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
